// File: rtl/axi3_sram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : axi3_sram_responder
// Purpose  : AXI3 slave word RAM (4-bit IDs, 32-bit data) with independent
//            read and write engines, one outstanding burst each. Backed by a
//            dual-port word RAM with per-byte write enables. Reports DECERR
//            for addresses outside the RAM span and SLVERR for beats wider
//            than the data bus or for a misplaced/missing wlast.
// Ports    : clk, reset                      - clock, sync active-high reset
//            ar*  (id/addr/len/size/burst)   - read address channel
//            r*   (id/data/resp/last)        - read data channel
//            aw*  (id/addr/len/size/burst)   - write address channel
//            w*   (data/strb/last)           - write data channel
//            b*   (id/resp)                  - write response channel
// Revision : 1.0 - initial release
// ============================================================================
module axi3_sram_responder #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int         c_DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [1:0] c_RESP_OKAY = 2'b00;
    localparam logic [1:0] c_RESP_SLV  = 2'b10;
    localparam logic [1:0] c_RESP_DEC  = 2'b11;
    localparam logic [1:0] c_BURST_FIX = 2'b00;
    localparam logic [1:0] c_BURST_WRP = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_SEND  = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // ------------------------------------------------------------------------
    // Shared helpers
    // ------------------------------------------------------------------------

    // Address of the next beat. WRAP keeps the bits above the wrap window and
    // lets only the in-window bits roll over; legal AXI3 wrap lengths (2, 4,
    // 8, 16 beats) make the window a power of two so a mask is exact.
    function automatic logic [31:0] f_next_addr(
        input logic [31:0] addr,
        input logic [3:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [31:0] w_incr;
        logic [31:0] w_mask;
        w_incr = 32'd1 << size;
        w_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            c_BURST_FIX: f_next_addr = addr;
            c_BURST_WRP: f_next_addr = (addr & ~w_mask) | ((addr + w_incr) & w_mask);
            default:     f_next_addr = addr + w_incr;   // INCR and reserved 11
        endcase
    endfunction

    // Per-beat response; an unmapped address outranks an oversized beat.
    function automatic logic [1:0] f_beat_resp(
        input logic [31:0] addr,
        input logic [2:0]  size
    );
        if ((addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
            f_beat_resp = c_RESP_DEC;
        end else if (size > 3'd2) begin
            f_beat_resp = c_RESP_SLV;
        end else begin
            f_beat_resp = c_RESP_OKAY;
        end
    endfunction

    // Severity order OKAY(00) < SLVERR(10) < DECERR(11) matches numeric order.
    function automatic logic [1:0] f_worst(input logic [1:0] a, input logic [1:0] b);
        f_worst = (a > b) ? a : b;
    endfunction

    // ------------------------------------------------------------------------
    // Storage (contents survive reset)
    // ------------------------------------------------------------------------
    logic [31:0] r_mem [0:c_DEPTH-1];

    // ------------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------------
    rd_state_t             r_rstate;
    rd_state_t             w_rnext;
    logic [31:0]           r_araddr;
    logic [3:0]            r_arlen;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;
    logic [3:0]            r_rbeat;
    logic [3:0]            r_rid;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;
    logic                  w_arready;
    logic                  w_rvalid;
    logic [1:0]            w_rd_resp;
    logic [ADDR_WIDTH-1:0] w_rd_idx;

    assign w_rd_resp = f_beat_resp(r_araddr, r_arsize);
    assign w_rd_idx  = r_araddr[ADDR_WIDTH+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rnext;
        end
    end

    always_comb begin
        w_rnext   = r_rstate;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (arvalid) begin
                    w_rnext = R_FETCH;
                end
            end
            R_FETCH: begin
                w_rnext = R_SEND;
            end
            R_SEND: begin
                w_rvalid = 1'b1;
                if (rready) begin
                    w_rnext = r_rlast ? R_IDLE : R_FETCH;
                end
            end
            default: begin
                w_rnext = R_IDLE;
            end
        endcase
    end

    // The response registers are loaded only in R_FETCH, so they stay put
    // for as long as the master stalls rready in R_SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_araddr  <= 32'd0;
            r_arlen   <= 4'd0;
            r_arsize  <= 3'd0;
            r_arburst <= 2'd0;
            r_rbeat   <= 4'd0;
            r_rid     <= 4'd0;
            r_rdata   <= 32'd0;
            r_rresp   <= c_RESP_OKAY;
            r_rlast   <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        r_araddr  <= araddr;
                        r_arlen   <= arlen;
                        r_arsize  <= arsize;
                        r_arburst <= arburst;
                        r_rid     <= arid;
                        r_rbeat   <= 4'd0;
                    end
                end
                R_FETCH: begin
                    // Same-cycle write to this word lands after this read,
                    // so the fetch returns the old contents.
                    r_rdata <= (w_rd_resp == c_RESP_OKAY) ? r_mem[w_rd_idx] : 32'd0;
                    r_rresp <= w_rd_resp;
                    r_rlast <= (r_rbeat == r_arlen);
                end
                R_SEND: begin
                    if (rready && !r_rlast) begin
                        r_araddr <= f_next_addr(r_araddr, r_arlen, r_arsize, r_arburst);
                        r_rbeat  <= r_rbeat + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign arready = w_arready;
    assign rvalid  = w_rvalid;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

    // ------------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------------
    wr_state_t             r_wstate;
    wr_state_t             w_wnext;
    logic [31:0]           r_awaddr;
    logic [3:0]            r_awlen;
    logic [2:0]            r_awsize;
    logic [1:0]            r_awburst;
    logic [3:0]            r_wbeat;
    logic [3:0]            r_bid;
    logic [1:0]            r_bresp;
    logic                  w_awready;
    logic                  w_wready;
    logic                  w_bvalid;
    logic [1:0]            w_wr_resp;
    logic                  w_wr_last_beat;
    logic                  w_wr_fire;
    logic                  w_mem_we;
    logic [1:0]            w_beat_status;
    logic [ADDR_WIDTH-1:0] w_wr_idx;

    assign w_wr_resp      = f_beat_resp(r_awaddr, r_awsize);
    assign w_wr_last_beat = (r_wbeat == r_awlen);
    assign w_wr_fire      = (r_wstate == W_DATA) && wvalid;
    // Reset aborts in the same cycle, so no beat is committed while it is high.
    assign w_mem_we       = w_wr_fire && (w_wr_resp == c_RESP_OKAY) && !reset;
    assign w_wr_idx       = r_awaddr[ADDR_WIDTH+1:2];
    // A wlast that disagrees with the beat count flags SLVERR; the burst
    // length still comes from awlen.
    assign w_beat_status  = f_worst(w_wr_resp,
                                    (wlast != w_wr_last_beat) ? c_RESP_SLV : c_RESP_OKAY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wnext;
        end
    end

    always_comb begin
        w_wnext   = r_wstate;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                if (awvalid) begin
                    w_wnext = W_DATA;
                end
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (wvalid && w_wr_last_beat) begin
                    w_wnext = W_RESP;
                end
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (bready) begin
                    w_wnext = W_IDLE;
                end
            end
            default: begin
                w_wnext = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_awaddr  <= 32'd0;
            r_awlen   <= 4'd0;
            r_awsize  <= 3'd0;
            r_awburst <= 2'd0;
            r_wbeat   <= 4'd0;
            r_bid     <= 4'd0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        r_awaddr  <= awaddr;
                        r_awlen   <= awlen;
                        r_awsize  <= awsize;
                        r_awburst <= awburst;
                        r_bid     <= awid;
                        r_wbeat   <= 4'd0;
                        r_bresp   <= c_RESP_OKAY;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        r_awaddr <= f_next_addr(r_awaddr, r_awlen, r_awsize, r_awburst);
                        r_wbeat  <= r_wbeat + 4'd1;
                        r_bresp  <= f_worst(r_bresp, w_beat_status);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign awready = w_awready;
    assign wready  = w_wready;
    assign bvalid  = w_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;

endmodule
`default_nettype wire

// File: tb/tb_axi3_sram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi3_sram_responder
// Purpose  : Self-checking bench for axi3_sram_responder: reset values, a
//            table of single-beat reads, directed multi-cycle sequences and
//            randomized bursts against a byte-addressed reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi3_sram_responder;

    localparam int ADDR_WIDTH = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axi3_sram_responder #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no response within 50 cycles, expected a handshake", name);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: byte-span memory image and closed-form beat addresses
    // ------------------------------------------------------------------------
    logic [31:0] m_mem [0:(1<<ADDR_WIDTH)-1];

    function automatic logic [31:0] mdl_addr(input logic [31:0] a, input logic [3:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int k);
        logic [31:0] sz;
        logic [31:0] wb;
        logic [31:0] base;
        sz = 32'd1 << size;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            wb   = (32'(len) + 32'd1) * sz;
            base = (a / wb) * wb;
            return base + (((a - base) + 32'(k) * sz) % wb);
        end
        return a + 32'(k) * sz;
    endfunction

    function automatic logic [1:0] mdl_resp(input logic [31:0] a, input logic [2:0] size);
        if (a >= (32'd1 << (ADDR_WIDTH + 2))) return 2'b11;
        if (size > 3'd2) return 2'b10;
        return 2'b00;
    endfunction

    // ------------------------------------------------------------------------
    // Channel drivers
    // ------------------------------------------------------------------------
    logic [31:0] g_rdata [16];
    logic [1:0]  g_rresp [16];
    logic        g_rlast [16];
    logic [3:0]  g_rid   [16];
    int          g_lat   [16];
    int          g_rbeats;
    bit          rnd_stall = 1'b0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_n);
        int t;
        int hs;
        int st;
        logic [31:0] held;
        g_rbeats = 0;
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (arready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) begin arvalid = 1'b0; timeout_fail("ar_handshake"); return; end
        hs = cyc;
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            t = 0;
            while (rvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) begin timeout_fail("r_beat"); return; end
            g_lat[k]   = cyc - hs;
            g_rdata[k] = rdata;
            g_rresp[k] = rresp;
            g_rlast[k] = rlast;
            g_rid[k]   = rid;
            st   = (k == stall_beat) ? stall_n : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            held = rdata;
            for (int s = 0; s < st; s++) begin
                @(posedge clk); #1;
                check("r_hold_data", rdata, held);
                check("r_hold_valid", 32'(rvalid), 32'd1);
            end
            rready = 1'b1;
            hs = cyc;
            @(posedge clk); #1;
            rready = 1'b0;
            g_rbeats++;
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                            output logic [1:0] bresp_o, output logic [3:0] bid_o, output int acc);
        int t;
        int gap;
        bresp_o = 2'b00; bid_o = 4'd0; acc = 0;
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (awready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) begin awvalid = 1'b0; timeout_fail("aw_handshake"); return; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            gap = rnd_stall ? int'($urandom_range(0, 2)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k];
            wlast  = (k == int'(len)) ^ (k == bad_beat);
            t = 0;
            while (wready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) begin wvalid = 1'b0; wlast = 1'b0; timeout_fail("w_beat"); return; end
            @(posedge clk); #1;
            wvalid = 1'b0; wlast = 1'b0;
            acc++;
        end
        check("w_ready_after_last", 32'(wready), 32'd0);
        t = 0;
        while (bvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) begin timeout_fail("b_resp"); return; end
        gap = rnd_stall ? int'($urandom_range(0, 2)) : 0;
        for (int s = 0; s < gap; s++) begin
            @(posedge clk); #1;
            check("b_hold_valid", 32'(bvalid), 32'd1);
        end
        bresp_o = bresp; bid_o = bid;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic read_and_check(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                                  input logic [2:0] size, input logic [1:0] burst,
                                  input int stall_beat, input int stall_n, input string tag);
        logic [31:0] ea;
        logic [1:0]  er;
        do_read(id, a, len, size, burst, stall_beat, stall_n);
        check($sformatf("%s_beats", tag), 32'(g_rbeats), 32'(len) + 32'd1);
        for (int k = 0; k < g_rbeats; k++) begin
            ea = mdl_addr(a, len, size, burst, k);
            er = mdl_resp(ea, size);
            check($sformatf("%s_data[%0d]", tag, k), g_rdata[k],
                  (er == 2'b00) ? m_mem[ea[ADDR_WIDTH+1:2]] : 32'd0);
            check($sformatf("%s_resp[%0d]", tag, k), 32'(g_rresp[k]), 32'(er));
            check($sformatf("%s_id[%0d]", tag, k), 32'(g_rid[k]), 32'(id));
            check($sformatf("%s_last[%0d]", tag, k), 32'(g_rlast[k]), 32'(k == int'(len)));
            check($sformatf("%s_lat[%0d]", tag, k), 32'(g_lat[k]), 32'd2);
        end
    endtask

    task automatic write_and_check(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                                   input logic [2:0] size, input logic [1:0] burst,
                                   input int bad_beat, input string tag);
        logic [1:0]  got_resp;
        logic [3:0]  got_id;
        int          acc;
        logic [31:0] ea;
        logic [1:0]  er;
        logic [1:0]  worst;
        do_write(id, a, len, size, burst, bad_beat, got_resp, got_id, acc);
        worst = 2'b00;
        for (int k = 0; k <= int'(len); k++) begin
            ea = mdl_addr(a, len, size, burst, k);
            er = mdl_resp(ea, size);
            if (er == 2'b00)
                for (int b = 0; b < 4; b++)
                    if (ws[k][b]) m_mem[ea[ADDR_WIDTH+1:2]][8*b +: 8] = wd[k][8*b +: 8];
            if (er > worst) worst = er;
            if (k == bad_beat && worst < 2'b10) worst = 2'b10;
        end
        check($sformatf("%s_bresp", tag), 32'(got_resp), 32'(worst));
        check($sformatf("%s_bid", tag), 32'(got_id), 32'(id));
        check($sformatf("%s_accepted", tag), 32'(acc), 32'(len) + 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Single-beat read vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } rd_vec_t;

    rd_vec_t tbl [10];

    initial begin
        logic [31:0] old;
        int          t;
        logic [3:0]  rlen;
        logic [1:0]  rb;
        logic [2:0]  rs;
        logic [31:0] ra;
        int          bad;

        reset = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_rid",     32'(rid),     32'd0);
        check("rst_rlast",   32'(rlast),   32'd0);
        check("rst_bid",     32'(bid),     32'd0);
        check("rst_bresp",   32'(bresp),   32'd0);

        // Fill words 0..255 with 0x1000_0000 + word index.
        for (int blk = 0; blk < 16; blk++) begin
            for (int k = 0; k < 16; k++) begin
                wd[k] = 32'h1000_0000 + 32'(blk * 16 + k);
                ws[k] = 4'hF;
            end
            write_and_check(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 2'b01, -1, "init");
        end

        tbl[0] = '{4'd1,  32'h0000_0000, 3'd2, 2'b01, 32'h1000_0000, 2'b00};
        tbl[1] = '{4'd2,  32'h0000_03FC, 3'd2, 2'b01, 32'h1000_00FF, 2'b00};
        tbl[2] = '{4'd3,  32'h0000_4000, 3'd2, 2'b01, 32'h0000_0000, 2'b11};
        tbl[3] = '{4'd4,  32'h0000_0080, 3'd3, 2'b01, 32'h0000_0000, 2'b10};
        tbl[4] = '{4'd5,  32'h0000_0020, 3'd2, 2'b00, 32'h1000_0008, 2'b00};
        tbl[5] = '{4'd6,  32'hFFFF_FFFC, 3'd2, 2'b01, 32'h0000_0000, 2'b11};
        tbl[6] = '{4'd7,  32'h0000_3FFC, 3'd3, 2'b01, 32'h0000_0000, 2'b10};
        tbl[7] = '{4'd8,  32'h0000_0044, 3'd1, 2'b01, 32'h1000_0011, 2'b00};
        tbl[8] = '{4'd9,  32'h0000_0007, 3'd0, 2'b01, 32'h1000_0001, 2'b00};
        tbl[9] = '{4'd10, 32'h8000_0040, 3'd3, 2'b10, 32'h0000_0000, 2'b11};

        for (int i = 0; i < 10; i++) begin
            do_read(tbl[i].id, tbl[i].addr, 4'd0, tbl[i].size, tbl[i].burst, -1, 0);
            check($sformatf("tbl%0d_beats", i), 32'(g_rbeats), 32'd1);
            check($sformatf("tbl%0d_data", i), g_rdata[0], tbl[i].exp_data);
            check($sformatf("tbl%0d_resp", i), 32'(g_rresp[0]), 32'(tbl[i].exp_resp));
            check($sformatf("tbl%0d_id", i), 32'(g_rid[0]), 32'(tbl[i].id));
            check($sformatf("tbl%0d_last", i), 32'(g_rlast[0]), 32'd1);
        end

        // Single read after a full-word write.
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        write_and_check(4'd3, 32'h40, 4'd0, 3'd2, 2'b01, -1, "wr_dead");
        do_read(4'd5, 32'h40, 4'd0, 3'd2, 2'b01, -1, 0);
        check("single_data", g_rdata[0], 32'hDEAD_BEEF);
        check("single_id",   32'(g_rid[0]), 32'd5);
        check("single_resp", 32'(g_rresp[0]), 32'd0);
        check("single_last", 32'(g_rlast[0]), 32'd1);
        check("single_lat",  32'(g_lat[0]), 32'd2);

        // WRAP read with a 3-cycle rready stall on the second beat.
        read_and_check(4'd6, 32'h38, 4'd3, 3'd2, 2'b10, 1, 3, "wrap");
        check("wrap_word2", g_rdata[2], 32'h1000_000C);
        check("wrap_last2", 32'(g_rlast[2]), 32'd0);

        // Byte-strobed INCR write.
        wd[0] = 32'h1122_3344; ws[0] = 4'b0001;
        wd[1] = 32'hAABB_CCDD; ws[1] = 4'b1100;
        write_and_check(4'd9, 32'h100, 4'd1, 3'd2, 2'b01, -1, "strb");
        read_and_check(4'd1, 32'h100, 4'd1, 3'd2, 2'b01, -1, 0, "strb_rd");
        check("strb_word0", g_rdata[0], 32'h1000_0044);
        check("strb_word1", g_rdata[1], 32'hAABB_0041);

        // Out-of-range write leaves word 0 (same low index bits) untouched.
        wd[0] = 32'h5555_5555; ws[0] = 4'hF;
        write_and_check(4'hA, 32'h4000, 4'd0, 3'd2, 2'b01, -1, "oor_wr");
        read_and_check(4'd2, 32'h0, 4'd0, 3'd2, 2'b01, -1, 0, "oor_rd");
        check("oor_word0", g_rdata[0], 32'h1000_0000);

        // wlast asserted early on beat 0, then wlast missing on the last beat.
        for (int k = 0; k < 3; k++) begin wd[k] = 32'hE000_0000 + 32'(k); ws[k] = 4'hF; end
        write_and_check(4'hB, 32'h200, 4'd2, 3'd2, 2'b01, 0, "early_wlast");
        write_and_check(4'hC, 32'h210, 4'd2, 3'd2, 2'b01, 2, "missing_wlast");
        read_and_check(4'd3, 32'h200, 4'd2, 3'd2, 2'b01, -1, 0, "wlast_rd");

        // Write beat and read fetch hit the same word in the same cycle.
        old = m_mem[32'h280 >> 2];
        awid = 4'hC; awaddr = 32'h280; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        t = 0;
        while (awready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        arid = 4'hD; araddr = 32'h280; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        check("conc_arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("conc_wready", 32'(wready), 32'd1);
        wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
        check("conc_rvalid", 32'(rvalid), 32'd1);
        check("conc_old_data", rdata, old);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        t = 0;
        while (bvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check("conc_bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        m_mem[32'h280 >> 2] = 32'hCAFE_F00D;
        read_and_check(4'hD, 32'h280, 4'd0, 3'd2, 2'b01, -1, 0, "conc_new");

        // Reset while a len=7 read sits in R_SEND.
        arid = 4'h4; araddr = 32'h0; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        t = 0;
        while (arready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        t = 0;
        while (rvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check("rst_mid_rvalid_before", 32'(rvalid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_arready", 32'(arready), 32'd1);
        reset = 1'b0;
        read_and_check(4'h7, 32'h10, 4'd0, 3'd2, 2'b01, -1, 0, "after_rst");

        // Randomized bursts with random handshake stalls.
        rnd_stall = 1'b1;
        for (int it = 0; it < 80; it++) begin
            rb   = 2'($urandom_range(0, 3));
            if (rb == 2'b10) rlen = 4'((2 << $urandom_range(0, 3)) - 1);
            else             rlen = 4'($urandom_range(0, 15));
            rs   = ($urandom_range(0, 11) < 10) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            ra   = ($urandom_range(0, 9) == 0) ? 32'h4000 + 32'($urandom_range(0, 32'hFFFF))
                                               : 32'($urandom_range(0, 32'h3BF));
            if ($urandom_range(0, 1) == 0) begin
                read_and_check(4'($urandom_range(0, 15)), ra, rlen, rs, rb, -1, 0,
                               $sformatf("rnd%0d_rd", it));
            end else begin
                for (int k = 0; k < 16; k++) begin
                    wd[k] = $urandom;
                    ws[k] = 4'($urandom_range(0, 15));
                end
                bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(rlen))) : -1;
                write_and_check(4'($urandom_range(0, 15)), ra, rlen, rs, rb, bad,
                                $sformatf("rnd%0d_wr", it));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
